// File: rtl/mem_load_resp_queue.sv
// In-order load/store response queue between the data SRAM and WB; optional MEM_RESP_BYPASS_EN.
// Latency: data_ok at N -> resp_valid at N+1 (same cycle with MEM_RESP_BYPASS_EN when queue has no filled entries).
// Backpressure: req_ready drops when DEPTH entries are occupied; resp_ready=0 holds the head response.
module mem_load_resp_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [2:0]                 req_type,
    input  logic [1:0]                 req_addr_low2,
    input  logic [TAG_W-1:0]           req_tag,
    input  logic                       data_ok,
    input  logic [31:0]                rdata,
    input  logic                       cancel,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [31:0]                resp_data,
    output logic [TAG_W-1:0]           resp_tag,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       spurious_ok
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]       e_type  [DEPTH];
    logic [1:0]       e_low2  [DEPTH];
    logic [TAG_W-1:0] e_tag   [DEPTH];
    logic [31:0]      e_data  [DEPTH];
    logic             e_filled[DEPTH];
    logic             e_disc  [DEPTH];

    logic [PW-1:0] issue_ptr, fill_ptr, head_ptr;
    logic [CW-1:0] count;

    logic alloc, fill, head_live, stored_valid, auto_drop, byp, pop;

    function automatic logic [31:0] format_load(input logic [2:0] t, input logic [1:0] lo,
                                                input logic [31:0] d);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = lo[1] ? d[31:16] : d[15:0];
        b = d[{lo, 3'b000} +: 8];
        case (t[1:0])
            2'b11:   r = d;
            2'b01:   r = t[2] ? {16'h0000, h} : {{16{h[15]}}, h};
            2'b10:   r = t[2] ? {24'h000000, b} : {{24{b[7]}}, b};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    assign req_ready    = (count < CW'(DEPTH));
    assign alloc        = req_valid & req_ready;
    assign fill         = data_ok & (outstanding != '0);
    assign head_live    = (count != '0) & e_filled[head_ptr];
    assign stored_valid = head_live & ~e_disc[head_ptr] & ~cancel;
    assign auto_drop    = head_live & e_disc[head_ptr];

`ifdef MEM_RESP_BYPASS_EN
    // count==outstanding means nothing is filled, so the fill slot is the head slot
    assign byp = fill & (count == outstanding) & ~e_disc[head_ptr] & ~cancel;
`else
    assign byp = 1'b0;
`endif

    assign resp_valid = stored_valid | byp;
    assign resp_data  = format_load(e_type[head_ptr], e_low2[head_ptr],
                                    byp ? rdata : e_data[head_ptr]);
    assign resp_tag   = e_tag[head_ptr];
    assign pop        = (resp_valid & resp_ready) | auto_drop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_type[i]   <= '0;
                e_low2[i]   <= '0;
                e_tag[i]    <= '0;
                e_data[i]   <= '0;
                e_filled[i] <= 1'b0;
                e_disc[i]   <= 1'b0;
            end
            issue_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            count       <= '0;
            outstanding <= '0;
            spurious_ok <= 1'b0;
        end else begin
            if (cancel) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!e_filled[i]) e_disc[i] <= 1'b1;
                end
            end
            if (fill) begin
                if (!(byp & resp_ready)) begin
                    e_data[fill_ptr]   <= rdata;
                    e_filled[fill_ptr] <= 1'b1;
                end
                if (cancel) e_disc[fill_ptr] <= 1'b1;
                fill_ptr <= fill_ptr + 1'b1;
            end
            if (alloc) begin
                e_type[issue_ptr]   <= req_type;
                e_low2[issue_ptr]   <= req_addr_low2;
                e_tag[issue_ptr]    <= req_tag;
                e_filled[issue_ptr] <= 1'b0;
                e_disc[issue_ptr]   <= cancel;
                issue_ptr <= issue_ptr + 1'b1;
            end
            if (data_ok && outstanding == '0) spurious_ok <= 1'b1;
            outstanding <= outstanding + CW'(alloc) - CW'(fill);
            // Cancel drops every filled undelivered entry: only still-outstanding ones remain
            if (cancel) begin
                head_ptr <= fill_ptr;
                count    <= outstanding + CW'(alloc);
            end else begin
                head_ptr <= head_ptr + PW'(pop);
                count    <= count + CW'(alloc) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_mem_load_resp_queue.sv
// Randomized and directed bench for mem_load_resp_queue against a queue-based reference model.
module tb_mem_load_resp_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             resetn;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_type = '0;
    logic [1:0]       req_addr_low2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             data_ok = 1'b0;
    logic [31:0]      rdata = '0;
    logic             cancel = 1'b0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic [2:0]       outstanding;
    logic             spurious_ok;

    mem_load_resp_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr_low2(req_addr_low2), .req_tag(req_tag),
        .data_ok(data_ok), .rdata(rdata), .cancel(cancel),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .outstanding(outstanding), .spurious_ok(spurious_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       typ;
        logic [1:0]       low2;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             filled;
        logic             disc;
    } ent_t;

    ent_t        mq[$];
    logic        m_spur = 1'b0;
    logic        m_valid, m_byp;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_deliv = 0;
    logic [31:0] last_data = '0;
    logic [31:0] last_tag = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt_m(input logic [2:0] t, input logic [1:0] lo, input logic [31:0] d);
        int unsigned v;
        int unsigned sz;
        sz = t & 3;
        if (sz == 0) return 32'h0;
        if (sz == 3) return d;
        if (sz == 1) begin
            v = (lo >= 2) ? (d / 65536) : (d % 65536);
            if (t < 4 && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = (d >> (8 * lo)) % 256;
            if (t < 4 && v >= 128) v = v + 32'hFFFFFF00;
        end
        return v;
    endfunction

    function automatic int unfilled();
        int n = 0;
        foreach (mq[i]) if (!mq[i].filled) n++;
        return n;
    endfunction

    task automatic check_outputs();
        int sz, n_unf;
        logic ev;
        logic [31:0] ed;
        sz = mq.size();
        n_unf = unfilled();
        ev = sz > 0 && mq[0].filled && !mq[0].disc && !cancel;
        ed = ev ? fmt_m(mq[0].typ, mq[0].low2, mq[0].data) : 32'h0;
        m_byp = 1'b0;
`ifdef MEM_RESP_BYPASS_EN
        if (data_ok && n_unf > 0 && n_unf == sz && !mq[0].disc && !cancel) begin
            m_byp = 1'b1;
            ev = 1'b1;
            ed = fmt_m(mq[0].typ, mq[0].low2, rdata);
        end
`endif
        m_valid = ev;
        chk("req_ready", req_ready, sz < DEPTH);
        chk("outstanding", outstanding, n_unf);
        chk("resp_valid", resp_valid, ev);
        chk("spurious_ok", spurious_ok, m_spur);
        if (ev) begin
            chk("resp_data", resp_data, ed);
            chk("resp_tag", resp_tag, mq[0].tag);
        end
        if (resp_valid && resp_ready) begin
            last_data = resp_data;
            last_tag  = resp_tag;
            n_deliv++;
        end
    endtask

    task automatic model_update();
        int n_unf;
        logic alloc, fill, pop;
        ent_t e;
        n_unf = unfilled();
        alloc = req_valid && mq.size() < DEPTH;
        fill  = data_ok && n_unf > 0;
        if (data_ok && n_unf == 0) m_spur = 1'b1;
        if (cancel) begin
            while (mq.size() > 0 && mq[0].filled) void'(mq.pop_front());
            foreach (mq[i]) mq[i].disc = 1'b1;
            if (fill) begin
                mq[0].data = rdata;
                mq[0].filled = 1'b1;
            end
        end else if (m_byp && resp_ready) begin
            void'(mq.pop_front());
        end else begin
            pop = mq.size() > 0 && mq[0].filled && (mq[0].disc || (m_valid && resp_ready));
            if (pop) void'(mq.pop_front());
            if (fill) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].filled) begin
                        mq[i].data = rdata;
                        mq[i].filled = 1'b1;
                        break;
                    end
                end
            end
        end
        if (alloc) begin
            e.typ = req_type; e.low2 = req_addr_low2; e.tag = req_tag;
            e.data = '0; e.filled = 1'b0; e.disc = cancel;
            mq.push_back(e);
        end
    endtask

    // Called at posedge+1: drive, check mid-cycle, advance model, move to next posedge+1
    task automatic step(input logic rv, input logic [2:0] t, input logic [1:0] lo,
                        input logic [TAG_W-1:0] tg, input logic dok, input logic [31:0] rd,
                        input logic cx, input logic rr);
        req_valid = rv; req_type = t; req_addr_low2 = lo; req_tag = tg;
        data_ok = dok; rdata = rd; cancel = cx; resp_ready = rr;
        #4;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(0, 3'b000, 2'b00, '0, 0, 32'h0, 0, rr);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_outstanding"}, outstanding, 0);
        chk({tag, "_spurious"}, spurious_ok, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_resp_tag"}, resp_tag, 0);
    endtask

    logic [2:0] types [6] = '{3'b011, 3'b001, 3'b101, 3'b010, 3'b110, 3'b000};
    int         base;

    initial begin
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1 check_reset_values("reset");
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;

        // ld.b, low2=3, sign extension of 0x80
        step(1, 3'b010, 2'b11, 5'd7, 0, 32'h0, 0, 1);
        step(0, 3'b000, 2'b00, '0, 1, 32'h80FF_1234, 0, 1);
        idle(2, 1);
        chk("ldb_data", last_data, 32'hFFFF_FF80);
        chk("ldb_tag", last_tag, 32'd7);

        // ld.hu / ld.h upper half
        step(1, 3'b101, 2'b10, 5'd3, 0, 32'h0, 0, 1);
        step(0, 3'b000, 2'b00, '0, 1, 32'h9ABC_0000, 0, 1);
        idle(2, 1);
        chk("ldhu_data", last_data, 32'h0000_9ABC);
        step(1, 3'b001, 2'b10, 5'd4, 0, 32'h0, 0, 1);
        step(0, 3'b000, 2'b00, '0, 1, 32'h9ABC_0000, 0, 1);
        idle(2, 1);
        chk("ldh_data", last_data, 32'hFFFF_9ABC);

        // Fill to DEPTH with WB stalled, then a 5th request that must be ignored
        for (int i = 0; i < 4; i++) step(1, 3'b011, 2'b00, 5'(10 + i), 0, 32'h0, 0, 0);
        chk("full_ready", req_ready, 0);
        step(1, 3'b011, 2'b00, 5'd31, 0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 3'b000, 2'b00, '0, 1, 32'h1111_0000 + i, 0, 0);
        base = n_deliv;
        idle(5, 1);
        chk("full_deliv", n_deliv - base, 4);
        chk("full_last_tag", last_tag, 13);

        // Cancel with one filled and two outstanding
        for (int i = 0; i < 3; i++) step(1, 3'b011, 2'b00, 5'(20 + i), 0, 32'h0, 0, 0);
        step(0, 3'b000, 2'b00, '0, 1, 32'hDEAD_BEEF, 0, 0);
        base = n_deliv;
        step(0, 3'b000, 2'b00, '0, 0, 32'h0, 1, 1);
        step(0, 3'b000, 2'b00, '0, 1, 32'h2222_2222, 0, 1);
        step(0, 3'b000, 2'b00, '0, 1, 32'h3333_3333, 0, 1);
        idle(2, 1);
        chk("cxl_none", n_deliv - base, 0);
        chk("cxl_outst", outstanding, 0);
        step(1, 3'b011, 2'b00, 5'd9, 0, 32'h0, 0, 1);
        step(0, 3'b000, 2'b00, '0, 1, 32'h5555_AAAA, 0, 1);
        idle(2, 1);
        chk("cxl_after", last_data, 32'h5555_AAAA);

        // Streaming with alloc, fill and pop overlapping, wrapping the pointers
        base = n_deliv;
        step(1, 3'b011, 2'b00, 5'd0, 0, 32'h0, 0, 1);
        for (int i = 1; i < 10; i++) step(1, 3'b011, 2'b00, 5'(i), 1, 32'h100 + i - 1, 0, 1);
        step(0, 3'b000, 2'b00, '0, 1, 32'h109, 0, 1);
        idle(2, 1);
        chk("wrap_deliv", n_deliv - base, 10);
        chk("wrap_last", last_data, 32'h109);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            logic dok;
            dok = (unfilled() > 0) && ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 1), types[$urandom_range(0, 5)], 2'($urandom_range(0, 3)),
                 5'($urandom), dok, $urandom, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 20 && unfilled() > 0; c++) step(0, 3'b000, 2'b00, '0, 1, $urandom, 0, 1);
        idle(4, 1);

        // Spurious data_ok
        chk("pre_spur", spurious_ok, 0);
        step(0, 3'b000, 2'b00, '0, 1, 32'h0, 0, 1);
        idle(1, 1);
        chk("spur_set", spurious_ok, 1);

        // Asynchronous reset in the middle of a burst
        step(1, 3'b011, 2'b00, 5'd1, 0, 32'h0, 0, 0);
        step(1, 3'b011, 2'b00, 5'd2, 1, 32'h7777_7777, 0, 0);
        req_valid = 1'b0; data_ok = 1'b0; cancel = 1'b0; resp_ready = 1'b0;
        #2 resetn = 1'b0;
        #1 check_reset_values("midrst");
        mq.delete();
        m_spur = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        step(0, 3'b000, 2'b00, '0, 1, 32'h0, 0, 1);
        idle(1, 1);
        chk("rst_spur", spurious_ok, 1);
        step(1, 3'b110, 2'b01, 5'd17, 0, 32'h0, 0, 1);
        step(0, 3'b000, 2'b00, '0, 1, 32'h0000_F100, 0, 1);
        idle(2, 1);
        chk("rst_after_data", last_data, 32'h0000_00F1);
        chk("rst_after_tag", last_tag, 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
